hw_serial_frame_receiver: RTL

//  Receive end of the display shift-register bus driven by hw_registers_controller.

---
 rtl/hw_display_pkg.sv | 26 ++
 rtl/hw_serial_frame_receiver_if.sv | 32 +++
 rtl/bus_input_sync.sv | 32 +++
 rtl/hw_serial_frame_receiver.sv | 125 ++++++++++++
 4 files changed

// File: rtl/hw_display_pkg.sv
// Shared types for the display shift-register bus: register widths, receiver state
// encoding and the helper that classifies a received bit count.
package hw_display_pkg;

  localparam int DEF_REG_SIZE     = 8;
  localparam int DEF_NUM_DATA_REG = 6;

  typedef logic [DEF_REG_SIZE-1:0] digit_t;
  typedef logic [DEF_REG_SIZE-1:0] ctrl_t;

  typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} rx_state_t;

  // A frame is complete at exactly frame_bits; anything beyond is an overrun.
  function automatic rx_state_t state_of_count(input int unsigned cnt,
                                               input int unsigned frame_bits);
    if (cnt == 0)
      return IDLE;
    else if (cnt < frame_bits)
      return SHIFT;
    else if (cnt == frame_bits)
      return FULL;
    else
      return OVER;
  endfunction

endpackage

// File: rtl/hw_serial_frame_receiver_if.sv
// Display bus as seen by the receiver: five serial lines in, rebuilt registers and
// frame status out.
interface hw_serial_frame_receiver_if
  import hw_display_pkg::*;
#(
  parameter int REG_SIZE     = DEF_REG_SIZE,
  parameter int NUM_DATA_REG = DEF_NUM_DATA_REG
);

  logic                                  bit_clk_in;
  logic                                  nrst_in;
  logic                                  control_ser_in;
  logic                                  digit_ser_in;
  logic                                  control_reg_clk_in;
  logic [NUM_DATA_REG-1:0][REG_SIZE-1:0] dig_data_out;
  logic [REG_SIZE-1:0]                   control_out;
  logic                                  frame_valid;
  logic                                  frame_err;
  logic [15:0]                           frames_rx;
  rx_state_t                             rx_state;

  modport master (
    output bit_clk_in, nrst_in, control_ser_in, digit_ser_in, control_reg_clk_in,
    input  dig_data_out, control_out, frame_valid, frame_err, frames_rx, rx_state
  );

  modport slave (
    input  bit_clk_in, nrst_in, control_ser_in, digit_ser_in, control_reg_clk_in,
    output dig_data_out, control_out, frame_valid, frame_err, frames_rx, rx_state
  );

endinterface

// File: rtl/bus_input_sync.sv
// Multi-bit synchronizer (STAGES flops, min 2) followed by a one-flop edge detector.
module bus_input_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]             prev;

  // All lines share one chain so data stays aligned with the clocks it travels with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync_out = chain[STAGES-1];
  assign rise     = sync_out & ~prev;
  assign fall     = ~sync_out & prev;

endmodule

// File: rtl/hw_serial_frame_receiver.sv
// Receive end of the display shift-register bus: rebuilds the latched digit and
// control registers from the oversampled serial lines and flags short/long frames.
module hw_serial_frame_receiver
  import hw_display_pkg::*;
#(
  parameter int REG_SIZE     = DEF_REG_SIZE,
  parameter int NUM_DATA_REG = DEF_NUM_DATA_REG,
  parameter int SYNC_STAGES  = 2
) (
  input logic                        clk,
  input logic                        rst,
  hw_serial_frame_receiver_if.slave  bus
);

  localparam int FRAME_BITS = NUM_DATA_REG * REG_SIZE;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(FRAME_BITS);
  localparam cnt_t CNT_OVER = cnt_t'(FRAME_BITS + 1);

  logic [4:0] sync_lvl;
  logic [4:0] sync_rise;
  logic [4:0] sync_fall;

  bus_input_sync #(
    .WIDTH (5),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in({bus.control_reg_clk_in, bus.digit_ser_in, bus.control_ser_in,
               bus.nrst_in, bus.bit_clk_in}),
    .sync_out(sync_lvl),
    .rise    (sync_rise),
    .fall    (sync_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sync_rise[4:1], sync_fall[3:0], sync_lvl[0], sync_lvl[4]};

  logic clear_lvl;
  logic shift_ev;
  logic latch_ev;

  assign clear_lvl = ~sync_lvl[1];
  assign shift_ev  = sync_rise[0] & ~clear_lvl;
  assign latch_ev  = sync_fall[4] & ~clear_lvl;

  logic [FRAME_BITS-1:0] digit_sr;
  logic [REG_SIZE-1:0]   ctrl_sr;
  logic [FRAME_BITS-1:0] dig_q;
  logic [REG_SIZE-1:0]   ctrl_q;
  logic                  valid_q;
  logic                  err_q;
  logic [15:0]           frames_q;
  cnt_t                  bit_cnt;
  cnt_t                  next_cnt;
  rx_state_t             state;
  rx_state_t             next_state;

  // Latch reads the pre-shift registers, so a coincident shift never leaks into a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_sr <= '0;
      ctrl_sr  <= '0;
      dig_q    <= '0;
      ctrl_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (clear_lvl) begin
        digit_sr <= '0;
        ctrl_sr  <= '0;
      end else begin
        if (latch_ev) begin
          dig_q    <= digit_sr;
          ctrl_q   <= ctrl_sr;
          valid_q  <= 1'b1;
          err_q    <= (bit_cnt != CNT_FULL);
          frames_q <= frames_q + 16'd1;
        end
        if (shift_ev) begin
          digit_sr <= {digit_sr[FRAME_BITS-2:0], sync_lvl[3]};
          ctrl_sr  <= {ctrl_sr[REG_SIZE-2:0], sync_lvl[2]};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      state   <= IDLE;
    end else begin
      bit_cnt <= next_cnt;
      state   <= next_state;
    end
  end

  // Count saturates one past a full frame so an overrun can never look like a good frame.
  always_comb begin
    next_cnt   = bit_cnt;
    next_state = state;
    if (clear_lvl)
      next_cnt = '0;
    else if (latch_ev)
      next_cnt = shift_ev ? cnt_t'(1) : '0;
    else if (shift_ev && bit_cnt != CNT_OVER)
      next_cnt = bit_cnt + cnt_t'(1);
    next_state = state_of_count(32'(next_cnt), FRAME_BITS);
  end

  assign bus.dig_data_out = dig_q;
  assign bus.control_out  = ctrl_q;
  assign bus.frame_valid  = valid_q;
  assign bus.frame_err    = err_q;
  assign bus.frames_rx    = frames_q;
  assign bus.rx_state     = state;

endmodule
